// File: rtl/disp_scan_if.sv
// Display scan controller bus: enable/update request in, scan position and frame-stable display data out.
interface disp_scan_if;
    logic        en;
    logic        upd_req;
    logic [15:0] Hexs_in;
    logic [3:0]  point_in;
    logic [3:0]  LES_in;
    logic [1:0]  Scan;
    logic [15:0] Hexs;
    logic [3:0]  point;
    logic [3:0]  LES;
    logic        blank;
    logic        frame_tick;
    logic        upd_ack;

    modport master (
        output en, upd_req, Hexs_in, point_in, LES_in,
        input  Scan, Hexs, point, LES, blank, frame_tick, upd_ack
    );

    modport slave (
        input  en, upd_req, Hexs_in, point_in, LES_in,
        output Scan, Hexs, point, LES, blank, frame_tick, upd_ack
    );
endinterface

// File: rtl/disp_scan_ctrl.sv
// 4-digit multiplexed display scanner with per-digit blanking and frame-synchronous
// double-buffered update of the display data.
module disp_scan_ctrl #(
    parameter int unsigned DWELL_CYC = 50000,
    parameter int unsigned BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    disp_scan_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_SHOW  = 2'd2;

    localparam int unsigned CNT_MAX  = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC - 1 : BLANK_CYC - 1;
    localparam int unsigned CNT_W    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int unsigned DWELL_LD = DWELL_CYC - 1;
    // With no blanking, every digit (and the first after IDLE) starts directly in SHOW.
    localparam int unsigned FIRST_LD = (BLANK_CYC > 0) ? BLANK_CYC - 1 : DWELL_CYC - 1;
    localparam logic [1:0]  FIRST_ST = (BLANK_CYC > 0) ? S_BLANK : S_SHOW;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       scan_q, scan_d;
    logic [15:0]      hexs_q, hexs_d, sh_hexs_q, sh_hexs_d;
    logic [3:0]       point_q, point_d, sh_point_q, sh_point_d;
    logic [3:0]       les_q, les_d, sh_les_q, sh_les_d;
    logic             blank_q, blank_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             pend_q, pend_d;
    logic             frame_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            scan_q     <= 2'd0;
            hexs_q     <= 16'd0;
            point_q    <= 4'd0;
            les_q      <= 4'd0;
            sh_hexs_q  <= 16'd0;
            sh_point_q <= 4'd0;
            sh_les_q   <= 4'd0;
            blank_q    <= 1'b1;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            scan_q     <= scan_d;
            hexs_q     <= hexs_d;
            point_q    <= point_d;
            les_q      <= les_d;
            sh_hexs_q  <= sh_hexs_d;
            sh_point_q <= sh_point_d;
            sh_les_q   <= sh_les_d;
            blank_q    <= blank_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        scan_d      = scan_q;
        hexs_d      = hexs_q;
        point_d     = point_q;
        les_d       = les_q;
        sh_hexs_d   = sh_hexs_q;
        sh_point_d  = sh_point_q;
        sh_les_d    = sh_les_q;
        pend_d      = pend_q;
        ack_d       = 1'b0;
        frame_start = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.en) begin
                    state_d     = FIRST_ST;
                    cnt_d       = CNT_W'(FIRST_LD);
                    scan_d      = 2'd0;
                    frame_start = 1'b1;
                end
            end
            S_BLANK: begin
                if (cnt_q == '0) begin
                    state_d = S_SHOW;
                    cnt_d   = CNT_W'(DWELL_LD);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SHOW: begin
                if (cnt_q == '0) begin
                    state_d     = FIRST_ST;
                    cnt_d       = CNT_W'(FIRST_LD);
                    scan_d      = scan_q + 2'd1;
                    frame_start = (scan_q == 2'd3);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Disable overrides the scan sequence but leaves shadow data and pending intact.
        if (!bus.en) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            scan_d      = 2'd0;
            frame_start = 1'b0;
        end

        blank_d = (state_d != S_SHOW);
        tick_d  = frame_start;

        // Commit uses the shadow contents from before any coincident request.
        if (frame_start && pend_q) begin
            hexs_d  = sh_hexs_q;
            point_d = sh_point_q;
            les_d   = sh_les_q;
            ack_d   = 1'b1;
            pend_d  = 1'b0;
        end

        if (bus.upd_req) begin
            sh_hexs_d  = bus.Hexs_in;
            sh_point_d = bus.point_in;
            sh_les_d   = bus.LES_in;
            pend_d     = 1'b1;
        end
    end

    assign bus.Scan       = scan_q;
    assign bus.Hexs       = hexs_q;
    assign bus.point      = point_q;
    assign bus.LES        = les_q;
    assign bus.blank      = blank_q;
    assign bus.frame_tick = tick_q;
    assign bus.upd_ack    = ack_q;
endmodule
